// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IF and DM (DM first) and raises the pipeline busywait.
// Latency: mem_req_o one cycle after request; busywait_o drops in the ack cycle. Backpressure: busywait_o stalls every stage register.
// Completed results are held in done flags/rdata registers until the pipeline advances, so nothing is issued twice.
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 64
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic [DATA_W-1:0]   if_rdata_o,
    input  logic                dm_req_i,
    input  logic                dm_we_i,
    input  logic [DATA_W/8-1:0] dm_be_i,
    input  logic [ADDR_W-1:0]   dm_addr_i,
    input  logic [DATA_W-1:0]   dm_wdata_i,
    output logic [DATA_W-1:0]   dm_rdata_o,
    output logic                busywait_o,
    output logic                bus_err_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    input  logic                mem_ack_i
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {IDLE, S_DM, S_IF} state_t;

    state_t            state_q, state_d;
    logic              if_done_q, if_done_d, dm_done_q, dm_done_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
    logic              bus_err_q, bus_err_d;
    logic              we_q, we_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic pend_dm, pend_if, in_dm, in_if, timeout, cmp_dm, cmp_if;

    always_comb begin
        pend_dm    = dm_req_i & ~dm_done_q;
        pend_if    = if_req_i & ~if_done_q;
        in_dm      = (state_q == S_DM);
        in_if      = (state_q == S_IF);
        // an ack arriving in the last allowed cycle wins over the abort
        timeout    = (cnt_q == CNT_LAST) & ~mem_ack_i;
        cmp_dm     = in_dm & (mem_ack_i | timeout);
        cmp_if     = in_if & (mem_ack_i | timeout);
        busywait_o = (pend_dm & ~cmp_dm) | (pend_if & ~cmp_if);
        mem_req_o  = in_dm | in_if;
        if_rdata_o = (in_if & mem_ack_i) ? mem_rdata_i : if_rdata_q;
        dm_rdata_o = (in_dm & mem_ack_i) ? mem_rdata_i : dm_rdata_q;

        state_d    = state_q;
        cnt_d      = cnt_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        bus_err_d  = 1'b0;
        we_d       = we_q;
        be_d       = be_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (pend_dm) begin
                    state_d = S_DM;
                    we_d    = dm_we_i;
                    be_d    = dm_be_i;
                    addr_d  = dm_addr_i;
                    wdata_d = dm_wdata_i;
                end else if (pend_if) begin
                    state_d = S_IF;
                    we_d    = 1'b0;
                    be_d    = {BE_W{1'b1}};
                    addr_d  = if_addr_i;
                    wdata_d = '0;
                end
            end
            S_DM, S_IF: begin
                if (mem_ack_i || timeout) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    bus_err_d = ~mem_ack_i;
                    if (in_dm) dm_rdata_d = mem_ack_i ? mem_rdata_i : '0;
                    else       if_rdata_d = mem_ack_i ? mem_rdata_i : '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // a pipeline advance consumes every held result
        if (!busywait_o) begin
            dm_done_d = 1'b0;
            if_done_d = 1'b0;
        end else begin
            dm_done_d = dm_done_q | cmp_dm;
            if_done_d = if_done_q | cmp_if;
        end

        mem_we_o    = we_q;
        mem_be_o    = be_q;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        bus_err_o   = bus_err_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            if_done_q  <= 1'b0;
            dm_done_q  <= 1'b0;
            cnt_q      <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            bus_err_q  <= 1'b0;
            we_q       <= 1'b0;
            be_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            if_done_q  <= if_done_d;
            dm_done_q  <= dm_done_d;
            cnt_q      <= cnt_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            bus_err_q  <= bus_err_d;
            we_q       <= we_d;
            be_q       <= be_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a memory model answers the port, a request queue predicts issue order.
module tb_mem_port_arbiter;
    logic        clk_i = 0, rst_ni = 0;
    logic        if_req_i = 0, dm_req_i = 0, dm_we_i = 0, mem_ack_i = 0;
    logic [31:0] if_addr_i = 0, dm_addr_i = 0, dm_wdata_i = 0, mem_rdata_i = 0;
    logic [3:0]  dm_be_i = 0;
    logic [31:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o;
    logic        busywait_o, bus_err_o, mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_be_i(dm_be_i), .dm_addr_i(dm_addr_i),
        .dm_wdata_i(dm_wdata_i), .dm_rdata_o(dm_rdata_o),
        .busywait_o(busywait_o), .bus_err_o(bus_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    int          n_vec = 0, n_err = 0, n_txn = 0;
    logic [31:0] mem_m [logic [31:0]];
    txn_t        exp_q [$];
    txn_t        cur;
    bit          in_txn = 0, ack_en = 1, ack_rand = 0, force_ack = 0;
    int          ack_fixed = 0, ack_dly = 0, wcnt = 0;
    logic        s_bw, s_berr, s_req;
    logic [31:0] s_ifr, s_dmr;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    // Memory slave plus one clock cycle; entered and left just after a negedge.
    task automatic tick();
        logic [31:0] w;
        mem_ack_i   = 0;
        mem_rdata_i = $urandom();
        if (force_ack) begin
            mem_ack_i = 1;
        end else if (mem_req_o) begin
            if (!in_txn) begin
                in_txn  = 1;
                wcnt    = 0;
                ack_dly = ack_rand ? int'($urandom_range(0, 2)) : ack_fixed;
                cur     = '{mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o};
                n_txn++;
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL issue: unexpected txn addr=%h", mem_addr_o);
                end else begin
                    txn_t e = exp_q.pop_front();
                    if (cur.we !== e.we || cur.be !== e.be || cur.addr !== e.addr ||
                        (e.we && cur.wdata !== e.wdata)) begin
                        n_err++;
                        $display("FAIL issue: got %h want %h", cur, e);
                    end
                end
            end else begin
                n_vec++;
                if (cur !== txn_t'({mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o})) begin
                    n_err++;
                    $display("FAIL hold: mem_* changed to addr=%h want %h", mem_addr_o, cur.addr);
                end
            end
            if (ack_en && wcnt == ack_dly) begin
                mem_ack_i = 1;
                if (mem_we_o) begin
                    w = mem_rd(mem_addr_o);
                    for (int i = 0; i < 4; i++)
                        if (mem_be_o[i]) w[i*8 +: 8] = mem_wdata_o[i*8 +: 8];
                    mem_m[mem_addr_o] = w;
                end else begin
                    mem_rdata_i = mem_rd(mem_addr_o);
                end
                in_txn = 0;
            end
            wcnt++;
        end else begin
            in_txn = 0;
        end
        #1;
        s_bw = busywait_o; s_berr = bus_err_o; s_req = mem_req_o;
        s_ifr = if_rdata_o; s_dmr = dm_rdata_o;
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    // Holds the requests until the pipeline advances; returns the stall count and results.
    task automatic do_access(input bit ir, input logic [31:0] ia, input bit dr, input bit we,
                             input logic [3:0] be, input logic [31:0] da, input logic [31:0] wd,
                             output int stall, output logic [31:0] ifr, output logic [31:0] dmr);
        if_req_i = ir; if_addr_i = ia;
        dm_req_i = dr; dm_we_i = we; dm_be_i = be; dm_addr_i = da; dm_wdata_i = wd;
        if (dr) exp_q.push_back('{we, be, da, wd});
        if (ir) exp_q.push_back('{1'b0, 4'hF, ia, 32'h0});
        stall = 0;
        forever begin
            tick();
            if (!s_bw) break;
            stall++;
            if (stall > 40) begin
                n_vec++; n_err++;
                $display("FAIL timeout: busywait_o stuck high");
                break;
            end
        end
        ifr = s_ifr; dmr = s_dmr;
        if_req_i = 0; dm_req_i = 0;
    endtask

    task automatic test_reset();
        #1;
        n_vec++; if (mem_req_o !== 0) begin n_err++; $display("FAIL rst_req: %b want 0", mem_req_o); end
        n_vec++; if (bus_err_o !== 0) begin n_err++; $display("FAIL rst_err: %b want 0", bus_err_o); end
        n_vec++; if (busywait_o !== 0) begin n_err++; $display("FAIL rst_bw: %b want 0", busywait_o); end
        n_vec++; if (if_rdata_o !== 0 || dm_rdata_o !== 0) begin
            n_err++; $display("FAIL rst_rdata: if=%h dm=%h want 0", if_rdata_o, dm_rdata_o); end
        @(negedge clk_i);
        rst_ni = 1;
        @(negedge clk_i);
    endtask

    task automatic test_if_single();
        int st; logic [31:0] ir, dr; int t0 = n_txn;
        mem_m[32'h40] = 32'h00000013;
        ack_fixed = 1;
        do_access(1, 32'h40, 0, 0, 0, 0, 0, st, ir, dr);
        n_vec++; if (st != 2) begin n_err++; $display("FAIL if_stall: %0d want 2", st); end
        n_vec++; if (ir !== 32'h13) begin n_err++; $display("FAIL if_rdata: %h want 00000013", ir); end
        n_vec++; if (cur.we !== 0 || cur.be !== 4'hF) begin
            n_err++; $display("FAIL if_attr: we=%b be=%h want 0/F", cur.we, cur.be); end
        n_vec++; if (n_txn - t0 != 1) begin n_err++; $display("FAIL if_issue: %0d txns want 1", n_txn - t0); end
    endtask

    task automatic test_dual();
        int st; logic [31:0] ir, dr, ei, ed; int t0 = n_txn;
        ack_fixed = 0;
        ei = mem_rd(32'h44); ed = mem_rd(32'h100);
        do_access(1, 32'h44, 1, 0, 4'hF, 32'h100, 0, st, ir, dr);
        n_vec++; if (st != 3) begin n_err++; $display("FAIL dual_stall: %0d want 3", st); end
        n_vec++; if (dr !== ed) begin n_err++; $display("FAIL dual_dm: %h want %h", dr, ed); end
        n_vec++; if (ir !== ei) begin n_err++; $display("FAIL dual_if: %h want %h", ir, ei); end
        n_vec++; if (n_txn - t0 != 2) begin n_err++; $display("FAIL dual_issue: %0d txns want 2", n_txn - t0); end
    endtask

    task automatic test_store();
        int st; logic [31:0] ir, dr, old;
        ack_fixed = 3;
        old = mem_rd(32'h200);
        do_access(0, 0, 1, 1, 4'b0011, 32'h200, 32'hDEADBEEF, st, ir, dr);
        n_vec++; if (st != 4) begin n_err++; $display("FAIL st_stall: %0d want 4", st); end
        n_vec++; if (cur !== txn_t'({1'b1, 4'b0011, 32'h200, 32'hDEADBEEF})) begin
            n_err++; $display("FAIL st_attr: %h", cur); end
        ack_fixed = 0;
        do_access(0, 0, 1, 0, 4'hF, 32'h200, 0, st, ir, dr);
        n_vec++; if (dr !== {old[31:16], 16'hBEEF}) begin
            n_err++; $display("FAIL st_readback: %h want %h", dr, {old[31:16], 16'hBEEF}); end
    endtask

    task automatic test_abort();
        int st; logic [31:0] ir, dr;
        ack_en = 0;
        do_access(0, 0, 1, 0, 4'hF, 32'h300, 0, st, ir, dr);
        ack_en = 1;
        n_vec++; if (st != 4) begin n_err++; $display("FAIL ab_stall: %0d want 4", st); end
        n_vec++; if (s_berr !== 0) begin n_err++; $display("FAIL ab_early: bus_err %b want 0", s_berr); end
        tick();
        n_vec++; if (s_berr !== 1) begin n_err++; $display("FAIL ab_pulse: bus_err %b want 1", s_berr); end
        n_vec++; if (s_dmr !== 0) begin n_err++; $display("FAIL ab_rdata: %h want 0", s_dmr); end
        n_vec++; if (s_req !== 0 || s_bw !== 0) begin
            n_err++; $display("FAIL ab_idle: req=%b bw=%b want 0/0", s_req, s_bw); end
        tick();
        n_vec++; if (s_berr !== 0) begin n_err++; $display("FAIL ab_width: bus_err %b want 0", s_berr); end
    endtask

    task automatic test_reset_mid();
        ack_en = 0;
        if_req_i = 1; if_addr_i = 32'h80;
        exp_q.push_back('{1'b0, 4'hF, 32'h80, 32'h0});
        tick();
        n_vec++; if (mem_req_o !== 1) begin n_err++; $display("FAIL rm_req: %b want 1", mem_req_o); end
        rst_ni = 0; if_req_i = 0;
        #1;
        n_vec++; if (mem_req_o !== 0) begin n_err++; $display("FAIL rm_async: %b want 0", mem_req_o); end
        in_txn = 0; exp_q.delete();
        @(negedge clk_i);
        rst_ni = 1; ack_en = 1; force_ack = 1;
        tick();
        force_ack = 0;
        n_vec++; if (s_bw !== 0 || s_ifr !== 0) begin
            n_err++; $display("FAIL rm_late: bw=%b if_rdata=%h want 0/0", s_bw, s_ifr); end
        tick();
        n_vec++; if (s_req !== 0) begin n_err++; $display("FAIL rm_idle: req=%b want 0", s_req); end
    endtask

    task automatic test_back_to_back();
        int st; logic [31:0] ir, dr, e; int t0;
        ack_fixed = 0;
        for (int k = 0; k < 3; k++) begin
            t0 = n_txn;
            e = mem_rd(32'(k * 4));
            do_access(1, 32'(k * 4), 0, 0, 0, 0, 0, st, ir, dr);
            n_vec++; if (st != 1 || ir !== e || n_txn - t0 != 1) begin
                n_err++; $display("FAIL b2b[%0d]: stall=%0d rdata=%h txns=%0d want 1/%h/1", k, st, ir, n_txn - t0, e); end
        end
    endtask

    task automatic test_random();
        int st; logic [31:0] ir, dr, ia, da, wd, ei, ed; bit ri, rd, we; logic [3:0] be; int t0;
        ack_rand = 1;
        for (int n = 0; n < 300; n++) begin
            ri = 1'($urandom()); rd = 1'($urandom()); we = 1'($urandom());
            ia = {20'h0, 4'($urandom()), 6'($urandom()), 2'b00};
            da = {20'h1, 4'h0, 6'($urandom()), 2'b00};
            be = 4'($urandom()); wd = $urandom();
            ei = mem_rd(ia); ed = mem_rd(da);
            t0 = n_txn;
            do_access(ri, ia, rd, we, be, da, wd, st, ir, dr);
            n_vec++; if (n_txn - t0 != int'(ri) + int'(rd) || exp_q.size() != 0) begin
                n_err++; $display("FAIL rnd_issue[%0d]: %0d txns want %0d", n, n_txn - t0, int'(ri) + int'(rd)); end
            if (ri) begin
                n_vec++; if (ir !== ei) begin n_err++; $display("FAIL rnd_if[%0d]: %h want %h", n, ir, ei); end
            end
            if (rd && !we) begin
                n_vec++; if (dr !== ed) begin n_err++; $display("FAIL rnd_dm[%0d]: %h want %h", n, dr, ed); end
            end
            n_vec++; if (s_berr !== 0) begin n_err++; $display("FAIL rnd_err[%0d]: bus_err %b want 0", n, s_berr); end
        end
        ack_rand = 0;
    endtask

    initial begin
        @(negedge clk_i);
        test_reset();
        test_if_single();
        test_dual();
        test_store();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
